// File: rtl/adc_arb_pkg.sv
// ---------------------------------------------------------------------------
// adc_arb_pkg
//   Shared types and defaults for the ADC access arbiter.
//   - arb_state_t     : arbiter FSM states
//   - ADC_DATA_W      : default ADC sample width (two's complement)
//   - ADC_TIMEOUT_DEF : default conversion timeout in clock cycles
// ---------------------------------------------------------------------------
package adc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  localparam int ADC_DATA_W      = 12;
  localparam int ADC_TIMEOUT_DEF = 64;

endpackage : adc_arb_pkg

// File: rtl/adc_access_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin select: picks the lowest set request bit at or
//   above the pointer, wrapping to the lowest set bit overall if none is.
//   Ports:
//     req_i  in   NUM_REQ  request vector
//     ptr_i  in   IDX_W    round-robin pointer (highest-priority index)
//     gnt_o  out  NUM_REQ  one-hot pick (all zero when req_i is zero)
//     idx_o  out  IDX_W    binary index of the pick (0 when req_i is zero)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req_i[i] && (IDX_W'(i) >= ptr_i);
    end
    // Nothing at or above the pointer: wrap around to the full vector.
    cand = (|masked) ? masked : req_i;

    idx_o = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) idx_o = IDX_W'(i);
    end
    // Isolate the lowest set bit.
    gnt_o = cand & ~(cand - 1'b1);
  end

endmodule : rr_pick

// File: rtl/adc_access_arbiter.sv
// ---------------------------------------------------------------------------
// adc_access_arbiter
//   Shares one single-channel ADC between NUM_REQ requesters. Grants one
//   requester at a time (round-robin), runs the req/rdy conversion handshake
//   for it and returns the captured signed sample with a completion pulse.
//   All outputs come straight from registers.
//   Ports:
//     clk_i           in   1        system clock
//     reset_i         in   1        asynchronous reset, active-high
//     req_i           in   NUM_REQ  level request, one bit per requester
//     gnt_o           out  NUM_REQ  one-hot grant, held for the transaction
//     done_o          out  NUM_REQ  one-cycle completion pulse
//     timeout_o       out  1        one-cycle abort pulse, coincident with done_o
//     data_o          out  DATA_W   last captured sample (shared, held)
//     busy_o          out  1        arbiter not idle
//     adc_data_req_o  out  1        one-cycle conversion start pulse
//     adc_data_rdy_i  in   1        ADC data ready level
//     adc_data_i      in   DATA_W   ADC sample, stable while ready is high
// ---------------------------------------------------------------------------
module adc_access_arbiter
  import adc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ADC_DATA_W,
  parameter int TIMEOUT = ADC_TIMEOUT_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               timeout_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               busy_o,
  output logic               adc_data_req_o,
  input  logic               adc_data_rdy_i,
  input  logic [DATA_W-1:0]  adc_data_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  arb_state_t         state_q,   state_d;
  logic [TMR_W-1:0]   timer_q,   timer_d;
  logic [IDX_W-1:0]   ptr_q,     ptr_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;
  logic [NUM_REQ-1:0] done_q,    done_d;
  logic               timeout_q, timeout_d;
  logic [DATA_W-1:0]  data_q,    data_d;
  logic               adc_req_q, adc_req_d;
  logic               rdy_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               rdy_rise;
  logic               tmr_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Only a fresh rising edge counts; a level already high on WAIT entry is
  // stale data from an earlier conversion.
  assign rdy_rise = adc_data_rdy_i & ~rdy_q;
  assign tmr_last = (timer_q == TMR_W'(TIMEOUT - 1));

  // State register and all output/data registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      data_q    <= '0;
      adc_req_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      adc_req_q <= adc_req_d;
      rdy_q     <= adc_data_rdy_i;
    end
  end

  // Next-state logic and conversion timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) state_d = REQ;
      end
      REQ: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rdy_rise || tmr_last) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for ready to drop so the next conversion sees a clean edge.
        if (!adc_data_rdy_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and granted index.
  always_comb begin
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    adc_req_d = 1'b0;
    done_d    = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d     = pick_gnt;
          idx_d     = pick_idx;
          adc_req_d = 1'b1;
        end
      end
      WAIT: begin
        if (rdy_rise) begin
          // An edge on the final timer cycle still wins over the abort.
          data_d = adc_data_i;
          done_d = gnt_q;
        end else if (tmr_last) begin
          done_d    = gnt_q;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        gnt_d = '0;
        ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign gnt_o          = gnt_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;
  assign data_o         = data_q;
  assign adc_data_req_o = adc_req_q;
  assign busy_o         = (state_q != IDLE);

endmodule : adc_access_arbiter

// File: tb/tb_adc_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_access_arbiter
//   Self-checking bench for adc_access_arbiter (NUM_REQ=4, DATA_W=12,
//   TIMEOUT=64). A reference model tracks the round-robin pointer and the
//   shared sample register; an ADC model answers each conversion request.
// ---------------------------------------------------------------------------
module tb_adc_access_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int TOUT = 64;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] gnt_o;
  logic [NREQ-1:0] done_o;
  logic            timeout_o;
  logic [DW-1:0]   data_o;
  logic            busy_o;
  logic            adc_data_req_o;
  logic            adc_data_rdy_i;
  logic [DW-1:0]   adc_data_i;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_ptr  = 0;
  logic [DW-1:0] m_data = '0;

  adc_access_arbiter #(
    .NUM_REQ (NREQ),
    .DATA_W  (DW),
    .TIMEOUT (TOUT)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .data_o         (data_o),
    .busy_o         (busy_o),
    .adc_data_req_o (adc_data_req_o),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Round-robin rule: starting from the pointer, walk the requesters in
  // circular order and take the first one asking.
  function automatic int model_pick(input logic [NREQ-1:0] req);
    for (int k = 0; k < NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset_i        = 1'b1;
    req_i          = '0;
    adc_data_rdy_i = 1'b0;
    adc_data_i     = '0;
    m_ptr          = 0;
    m_data         = '0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  // One full transaction. delay = cycles after the grant/req pulse is seen
  // until the ADC raises ready (0 = ADC never answers). In stale mode ready
  // is already high when WAIT is entered, drops at cycle 3, and rises again
  // at cycle `delay` with the real sample.
  task automatic do_txn(input logic [NREQ-1:0] req, input int delay,
                        input logic [DW-1:0] din, input bit stale,
                        input bit drop, output int got_idx);
    int            exp_idx;
    logic [NREQ-1:0] exp_gnt;
    int            pulses;
    int            exp_c;
    int            c;
    bit            seen;
    exp_idx = model_pick(req);
    exp_gnt = NREQ'(1) << exp_idx;
    exp_c   = (delay == 0) ? TOUT + 1 : delay + 1;
    got_idx = -1;
    pulses  = 0;
    seen    = 1'b0;

    req_i = req;
    @(negedge clk_i);
    for (int i = 0; i < NREQ; i++) if (gnt_o[i]) got_idx = i;
    checks++;
    if ({gnt_o, adc_data_req_o, busy_o} !== {exp_gnt, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL grant: gnt=%b req=%b busy=%b, expected gnt=%b req=1 busy=1",
               gnt_o, adc_data_req_o, busy_o, exp_gnt);
    end
    if (gnt_o == '0) begin
      req_i = '0;
      repeat (4) @(negedge clk_i);
      return;
    end

    for (c = 0; c < 200; c++) begin
      if (adc_data_req_o) pulses++;
      if (done_o != '0) begin
        seen = 1'b1;
        break;
      end
      if (c > 0) begin
        checks++;
        if ({gnt_o, adc_data_req_o, busy_o, timeout_o} !== {exp_gnt, 3'b010} ||
            data_o !== m_data) begin
          errors++;
          $display("FAIL hold c=%0d: gnt=%b req=%b busy=%b to=%b data=%h, expected gnt=%b req=0 busy=1 to=0 data=%h",
                   c, gnt_o, adc_data_req_o, busy_o, timeout_o, data_o, exp_gnt, m_data);
        end
      end
      if (stale) begin
        if (c == 0) begin adc_data_rdy_i = 1'b1; adc_data_i = ~din; end
        if (c == 3) adc_data_rdy_i = 1'b0;
      end
      if (delay != 0 && c == delay) begin
        adc_data_rdy_i = 1'b1;
        adc_data_i     = din;
      end
      if (drop && c == 1) req_i = '0;
      @(negedge clk_i);
    end

    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_wait: no done_o within 200 cycles, expected at cycle %0d", exp_c);
      adc_data_rdy_i = 1'b0;
      req_i          = '0;
      repeat (4) @(negedge clk_i);
      return;
    end

    if (delay != 0) m_data = din;
    m_ptr = (exp_idx + 1) % NREQ;

    if (c !== exp_c || done_o !== exp_gnt || timeout_o !== (delay == 0) ||
        data_o !== m_data || pulses != 1) begin
      errors++;
      $display("FAIL done: cycle=%0d done=%b to=%b data=%h pulses=%0d, expected cycle=%0d done=%b to=%b data=%h pulses=1",
               c, done_o, timeout_o, data_o, pulses, exp_c, exp_gnt, delay == 0, m_data);
    end

    // DONE is one cycle; then RELEASE with the grant dropped.
    @(negedge clk_i);
    checks++;
    if ({done_o, timeout_o, gnt_o, adc_data_req_o, busy_o} !== {NREQ'(0), 1'b0, NREQ'(0), 2'b01} ||
        data_o !== m_data) begin
      errors++;
      $display("FAIL release: done=%b to=%b gnt=%b req=%b busy=%b data=%h, expected done=0 to=0 gnt=0 req=0 busy=1 data=%h",
               done_o, timeout_o, gnt_o, adc_data_req_o, busy_o, data_o, m_data);
    end
    if (adc_data_rdy_i) begin
      // Ready still high: the arbiter must keep waiting in RELEASE.
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b1 || gnt_o !== '0) begin
        errors++;
        $display("FAIL release_hold: busy=%b gnt=%b, expected busy=1 gnt=0", busy_o, gnt_o);
      end
    end
    adc_data_rdy_i = 1'b0;
    req_i          = '0;
    @(negedge clk_i);
    checks++;
    if ({busy_o, gnt_o, done_o, adc_data_req_o} !== '0 || data_o !== m_data) begin
      errors++;
      $display("FAIL idle: busy=%b gnt=%b done=%b req=%b data=%h, expected all 0 and data=%h",
               busy_o, gnt_o, done_o, adc_data_req_o, data_o, m_data);
    end
  endtask

  task automatic test_reset();
    reset_i        = 1'b1;
    req_i          = '0;
    adc_data_rdy_i = 1'b0;
    adc_data_i     = '0;
    #1;
    checks++;
    if ({gnt_o, done_o, timeout_o, data_o, busy_o, adc_data_req_o} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b done=%b to=%b data=%h busy=%b req=%b, expected all 0",
               gnt_o, done_o, timeout_o, data_o, busy_o, adc_data_req_o);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int idx;
    do_txn(4'b0001, 5, 12'h7FF, 1'b0, 1'b0, idx);
    checks++;
    if (idx != 0) begin
      errors++;
      $display("FAIL single_idx: granted %0d, expected 0", idx);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int idx;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      do_txn(4'b1111, 2 + t, DW'(12'h100 + t), 1'b0, 1'b0, idx);
      checks++;
      if (idx != order[t]) begin
        errors++;
        $display("FAIL rr_order[%0d]: granted %0d, expected %0d", t, idx, order[t]);
      end
    end
  endtask

  task automatic test_timeout();
    int idx;
    do_txn(4'b0010, 0, 12'hABC, 1'b0, 1'b0, idx);
  endtask

  task automatic test_stale_rdy();
    int idx;
    do_txn(4'b0100, 5, 12'h123, 1'b1, 1'b0, idx);
    checks++;
    if (data_o !== 12'h123) begin
      errors++;
      $display("FAIL stale: data=%h, expected 123", data_o);
    end
  endtask

  task automatic test_signed();
    int idx;
    do_txn(4'b1000, 3, 12'h800, 1'b0, 1'b0, idx);
    checks++;
    if (int'($signed(data_o)) != -2048) begin
      errors++;
      $display("FAIL signed_min: data=%0d, expected -2048", $signed(data_o));
    end
    do_txn(4'b1000, 4, 12'hFFF, 1'b0, 1'b0, idx);
    checks++;
    if (int'($signed(data_o)) != -1) begin
      errors++;
      $display("FAIL signed_neg1: data=%0d, expected -1", $signed(data_o));
    end
  endtask

  task automatic test_reset_mid_wait();
    int idx;
    // Leave the pointer at 3 so a stale pointer would pick requester 3 below.
    do_txn(4'b0100, 2, 12'h3C3, 1'b0, 1'b0, idx);
    req_i = 4'b1000;
    repeat (4) @(negedge clk_i);    // grant, REQ, then a few WAIT cycles
    reset_i = 1'b1;
    #1;
    checks++;
    if ({gnt_o, done_o, timeout_o, data_o, busy_o, adc_data_req_o} !== '0) begin
      errors++;
      $display("FAIL reset_async: gnt=%b done=%b to=%b data=%h busy=%b req=%b, expected all 0",
               gnt_o, done_o, timeout_o, data_o, busy_o, adc_data_req_o);
    end
    req_i = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    m_ptr   = 0;
    m_data  = '0;
    @(negedge clk_i);
    do_txn(4'b1100, 3, 12'h456, 1'b0, 1'b0, idx);
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL reset_ptr: granted %0d, expected 2", idx);
    end
  endtask

  task automatic test_random();
    int idx;
    for (int t = 0; t < 20; t++) begin
      logic [NREQ-1:0] req;
      int              delay;
      logic [DW-1:0]   din;
      bit              drop;
      req   = NREQ'($urandom_range(1, 15));
      delay = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      din   = DW'($urandom);
      drop  = ($urandom_range(0, 3) == 0);
      do_txn(req, delay, din, 1'b0, drop, idx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stale_rdy();
    test_signed();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adc_access_arbiter
